lcm_seq: RTL and testbench



---
 rtl/lcm_pkg.sv | 31 +++
 rtl/lcm_seq_if.sv | 16 +
 rtl/lcm_binary_gcd.sv | 69 ++++++
 rtl/lcm_seq.sv | 143 ++++++++++++++
 tb/tb_lcm_seq.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lcm_pkg.sv
// Shared definitions for the sequential LCM engine: state encoding, latency
// bound and a reference gcd used by scoreboards.
package lcm_pkg;

    localparam int unsigned LCM_W       = 32;
    localparam int unsigned LCM_MAX_CYC = 6 * LCM_W + 3;

    typedef logic [2:0] lcm_state_t;
    localparam lcm_state_t S_IDLE = 3'd0;
    localparam lcm_state_t S_GCD  = 3'd1;
    localparam lcm_state_t S_DIV  = 3'd2;
    localparam lcm_state_t S_MUL  = 3'd3;
    localparam lcm_state_t S_DONE = 3'd4;

    // Euclid's algorithm; 2*W iterations covers the worst (Fibonacci) case.
    function automatic logic [LCM_W-1:0] ref_gcd(input logic [LCM_W-1:0] a,
                                                 input logic [LCM_W-1:0] b);
        logic [LCM_W-1:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < 2 * LCM_W; i++) begin
            if (y != '0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/lcm_seq_if.sv
// Operand/result handshake bundle for the LCM engine.
interface lcm_seq_if #(parameter int W = 32);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   gcd;
    logic [2*W-1:0] lcm;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, gcd, lcm);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, gcd, lcm);
endinterface

// File: rtl/lcm_binary_gcd.sv
// Iterative binary (Stein) gcd: one step per cycle after start_i, done_o is
// high while the result on gcd_o is valid. Operands must be nonzero.
module lcm_binary_gcd #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] gcd_o
);
    localparam int KW = $clog2(W);

    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [KW-1:0] k_q, k_d;
    logic          busy_q, busy_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        k_d    = k_q;
        busy_d = busy_q;
        if (start_i) begin
            x_d    = a_i;
            y_d    = b_i;
            k_d    = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (x_q == y_q) begin
                busy_d = 1'b0;
            end else begin
                unique case ({x_q[0], y_q[0]})
                    2'b00: begin
                        x_d = x_q >> 1;
                        y_d = y_q >> 1;
                        k_d = k_q + 1'b1;
                    end
                    2'b01:   x_d = x_q >> 1;
                    2'b10:   y_d = y_q >> 1;
                    default: begin
                        // Both odd: comparator picks the order so no underflow.
                        if (x_q > y_q) x_d = x_q - y_q;
                        else           y_d = y_q - x_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            k_q    <= k_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = busy_q && (x_q == y_q);
    assign gcd_o  = x_q << k_q;

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM engine: Stein gcd, then a/g by restoring division and
// (a/g)*b by shift-add, both on one shared shift register and adder.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lcm_seq_if.slave  bus
);
    localparam int              CW       = $clog2(W);
    localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

    lcm_state_t       state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, g_q, g_d;
    logic [W-1:0]     sh_q, sh_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     gcd_q, gcd_d;
    logic [2*W-1:0]   lcm_q, lcm_d;
    logic             rdy_q;

    logic             in_fire, gcd_start, gcd_done;
    logic [W-1:0]     gcd_res;
    logic [W:0]       trial, add_a, add_b, sum;
    logic             add_ci, ge;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign gcd_start = in_fire && (bus.a != '0) && (bus.b != '0);

    lcm_binary_gcd #(.W(W)) u_gcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (gcd_start),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .done_o  (gcd_done),
        .gcd_o   (gcd_res)
    );

    // DIV: rem:sh shifts left, trial subtract of g. MUL: rem:sh is the
    // product register, sh holds the quotient multiplier and shifts right.
    always_comb begin
        trial = {rem_q, sh_q[W-1]};
        ge    = trial >= {1'b0, g_q};
        if (state_q == S_DIV) begin
            add_a  = trial;
            add_b  = ~{1'b0, g_q};
            add_ci = 1'b1;
        end else begin
            add_a  = {1'b0, rem_q};
            add_b  = sh_q[0] ? {1'b0, b_q} : '0;
            add_ci = 1'b0;
        end
        sum = add_a + add_b + {{W{1'b0}}, add_ci};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        lcm_d   = lcm_q;
        case (state_q)
            S_IDLE: if (in_fire) begin
                a_d = bus.a;
                b_d = bus.b;
                if (bus.a == '0 || bus.b == '0) begin
                    gcd_d   = bus.a | bus.b;
                    lcm_d   = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_GCD;
                end
            end
            S_GCD: if (gcd_done) begin
                g_d     = gcd_res;
                sh_d    = a_q;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                sh_d  = {sh_q[W-2:0], ge};
                rem_d = ge ? sum[W-1:0] : trial[W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    rem_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                rem_d = sum[W:1];
                sh_d  = {sum[0], sh_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    gcd_d   = g_q;
                    lcm_d   = {sum[W:1], sum[0], sh_q[W-1:1]};
                    state_d = S_DONE;
                end
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            lcm_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            lcm_q   <= lcm_d;
            // Keeps in_ready low until the first edge after reset release.
            rdy_q   <= 1'b1;
        end
    end

    assign bus.in_ready  = rdy_q && (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.gcd       = gcd_q;
    assign bus.lcm       = lcm_q;

endmodule

// File: tb/tb_lcm_seq.sv
// Directed-vector bench for lcm_seq: table of operand pairs with hand-computed
// gcd/lcm, plus backpressure and mid-operation reset sequences.
module tb_lcm_seq;
    import lcm_pkg::*;

    typedef struct {
        logic [LCM_W-1:0]   a;
        logic [LCM_W-1:0]   b;
        logic [LCM_W-1:0]   g;
        logic [2*LCM_W-1:0] l;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt[14];

    lcm_seq_if #(.W(LCM_W)) bus ();

    lcm_seq #(.W(LCM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Handshake one pair from a negedge, wait for the result, check, drain.
    task automatic run_vec(input logic [LCM_W-1:0] a, input logic [LCM_W-1:0] b,
                           input logic [LCM_W-1:0] eg, input logic [2*LCM_W-1:0] el,
                           input string tag);
        int               lat;
        logic [LCM_W-1:0] mg;
        logic [63:0]      ml;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat <= int'(LCM_MAX_CYC) + 4) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_gcd"}, 64'(bus.gcd), 64'(eg));
        chk({tag, "_lcm"}, bus.lcm, el);
        mg = ref_gcd(a, b);
        ml = (mg == '0) ? 64'd0 : 64'(a / mg) * 64'(b);
        chk({tag, "_gcd_model"}, 64'(bus.gcd), 64'(mg));
        chk({tag, "_lcm_model"}, bus.lcm, ml);
        if (a == '0 || b == '0) chk({tag, "_zero_lat"}, 64'(lat), 64'd1);
        else chk({tag, "_lat_le_bound"}, 64'(lat <= int'(LCM_MAX_CYC)), 64'd1);
        @(negedge clk);
        chk({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_gcd_held"}, 64'(bus.gcd), 64'(eg));
    endtask

    initial begin
        int n;
        vt[0]  = '{32'd48, 32'd18, 32'd6, 64'd144};
        vt[1]  = '{32'd123456789, 32'd987654321, 32'd9, 64'd13548070123626141};
        vt[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 64'hFFFFFFFD00000002};
        vt[3]  = '{32'd0, 32'd7, 32'd7, 64'd0};
        vt[4]  = '{32'd0, 32'd0, 32'd0, 64'd0};
        vt[5]  = '{32'd21, 32'd6, 32'd3, 64'd42};
        vt[6]  = '{32'd1, 32'd1, 32'd1, 64'd1};
        vt[7]  = '{32'd17, 32'd17, 32'd17, 64'd17};
        vt[8]  = '{32'd7, 32'd0, 32'd7, 64'd0};
        vt[9]  = '{32'd64, 32'd48, 32'd16, 64'd192};
        vt[10] = '{32'h80000000, 32'h80000000, 32'h80000000, 64'h80000000};
        vt[11] = '{32'd1000000007, 32'd2, 32'd1, 64'd2000000014};
        vt[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF};
        vt[13] = '{32'd35, 32'd49, 32'd7, 64'd245};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_gcd", 64'(bus.gcd), 64'd0);
        chk("rst_lcm", bus.lcm, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_vec(vt[i].a, vt[i].b, vt[i].g, vt[i].l, $sformatf("v%0d", i));

        // Backpressure: result must hold, in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'd12;
        bus.b         = 32'd8;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < int'(LCM_MAX_CYC) + 4) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_gcd", 64'(bus.gcd), 64'd4);
            chk("bp_lcm", bus.lcm, 64'd24);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_valid = (i % 3 == 0);
            bus.a        = 32'd5;
            bus.b        = 32'd3;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_idle_gcd", 64'(bus.gcd), 64'd4);
        chk("bp_idle_lcm", bus.lcm, 64'd24);
        @(negedge clk);
        chk("bp_single_handshake", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of the division phase.
        bus.in_valid = 1'b1;
        bus.a        = 32'd1000000007;
        bus.b        = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (dut.state_q != S_DIV && n < int'(LCM_MAX_CYC)) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_div", 64'(dut.state_q == S_DIV), 64'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_gcd", 64'(bus.gcd), 64'd0);
        chk("abort_lcm", bus.lcm, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_stale", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        run_vec(32'd4, 32'd6, 32'd2, 64'd12, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
